// File: rtl/writeback_stage_seq.sv
// Writeback stage: registered scalar RF write plus a vector write serialised into
// ceil(LANES/VWP) beats through a VWP-port vector register file.
module writeback_stage_seq #(
   parameter int WIDTH  = 8,
   parameter int LANES  = 4,
   parameter int LANE_W = 16,
   parameter int VWP    = 2,
   parameter int RA_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      mem_to_reg,
   input  logic                      vmem_to_reg,
   input  logic                      reg_write,
   input  logic                      vreg_write,
   input  logic [RA_W-1:0]           rd,
   input  logic [RA_W-1:0]           vd,
   input  logic [WIDTH-1:0]          read_data,
   input  logic [WIDTH-1:0]          alu_out,
   input  logic [LANES*LANE_W-1:0]   vread_data,
   input  logic [LANES*LANE_W-1:0]   valu_out,
   output logic                      rf_we,
   output logic [RA_W-1:0]           rf_waddr,
   output logic [WIDTH-1:0]          rf_wdata,
   output logic                      vrf_we,
   output logic [RA_W-1:0]           vrf_waddr,
   output logic [$clog2(LANES):0]    vrf_lane_base,
   output logic [VWP-1:0]            vrf_lane_mask,
   output logic [VWP*LANE_W-1:0]     vrf_wdata,
   output logic                      busy,
   output logic [RA_W-1:0]           busy_vd
);

   localparam int NB     = (LANES + VWP - 1) / VWP;
   localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int BASE_W = $clog2(LANES) + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      VWRITE = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          beat_q, beat_d;
   logic [RA_W-1:0]           vd_q, vd_d;
   logic [LANES*LANE_W-1:0]   vbuf_q, vbuf_d;

   logic                      rf_we_q, rf_we_d;
   logic [RA_W-1:0]           rf_waddr_q, rf_waddr_d;
   logic [WIDTH-1:0]          rf_wdata_q, rf_wdata_d;

   logic                      in_vwrite;
   logic                      last_beat;
   logic                      accept;

   assign in_vwrite = (state_q == VWRITE);
   assign last_beat = in_vwrite && (beat_q == CNT_W'(NB - 1));
   assign in_ready  = (state_q == IDLE) || last_beat;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         vd_q       <= '0;
         vbuf_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         vd_q       <= vd_d;
         vbuf_q     <= vbuf_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Accepts only happen in IDLE or on the last beat, so a new vector op always restarts at beat 0.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      vd_d    = vd_q;
      vbuf_d  = vbuf_q;
      if (accept && vreg_write) begin
         state_d = VWRITE;
         beat_d  = '0;
         vd_d    = vd;
         vbuf_d  = vmem_to_reg ? vread_data : valu_out;
      end else if (in_vwrite && !last_beat) begin
         beat_d  = beat_q + CNT_W'(1);
      end else begin
         state_d = IDLE;
         beat_d  = '0;
      end
   end

   always_comb begin
      rf_we_d    = accept && reg_write && (rd != '0);
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      if (rf_we_d) begin
         rf_waddr_d = rd;
         rf_wdata_d = mem_to_reg ? read_data : alu_out;
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;

   assign busy          = in_vwrite;
   assign busy_vd       = in_vwrite ? vd_q : '0;
   assign vrf_we        = in_vwrite;
   assign vrf_waddr     = in_vwrite ? vd_q : '0;
   assign vrf_lane_base = in_vwrite ? BASE_W'(int'(beat_q) * VWP) : '0;

   // Each write port carries one lane of the current beat; ports past the last lane stay dark.
   genvar gi;
   generate
      for (gi = 0; gi < VWP; gi++) begin : g_slot
         int                      slot_lane;
         logic [LANES*LANE_W-1:0] shifted;
         logic                    slot_en;
         logic [LANE_W-1:0]       slot_data;

         always_comb begin
            slot_lane = int'(beat_q) * VWP + gi;
            shifted   = vbuf_q >> (slot_lane * LANE_W);
            slot_en   = in_vwrite && (slot_lane < LANES);
            slot_data = slot_en ? shifted[LANE_W-1:0] : '0;
         end

         assign vrf_lane_mask[gi]                = slot_en;
         assign vrf_wdata[gi*LANE_W +: LANE_W]   = slot_data;
      end
   endgenerate

endmodule

// File: tb/tb_writeback_stage_seq.sv
// Directed bench for writeback_stage_seq: default 4-lane/2-port instance plus a 3-lane instance.
module tb_writeback_stage_seq;

   logic        clk;
   logic        rst;
   logic        in_valid, mem_to_reg, vmem_to_reg, reg_write, vreg_write;
   logic [3:0]  rd, vd;
   logic [7:0]  read_data, alu_out;
   logic [63:0] vread_data, valu_out;

   logic        in_ready, rf_we, vrf_we, busy;
   logic [3:0]  rf_waddr, vrf_waddr, busy_vd;
   logic [7:0]  rf_wdata;
   logic [2:0]  vrf_lane_base;
   logic [1:0]  vrf_lane_mask;
   logic [31:0] vrf_wdata;

   logic        t3_in_ready, t3_rf_we, t3_vrf_we, t3_busy;
   logic [3:0]  t3_rf_waddr, t3_vrf_waddr, t3_busy_vd;
   logic [7:0]  t3_rf_wdata;
   logic [2:0]  t3_lane_base;
   logic [1:0]  t3_lane_mask;
   logic [31:0] t3_wdata;

   int tests = 0;
   int fails = 0;

   writeback_stage_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem_to_reg(mem_to_reg), .vmem_to_reg(vmem_to_reg), .reg_write(reg_write),
      .vreg_write(vreg_write), .rd(rd), .vd(vd), .read_data(read_data), .alu_out(alu_out),
      .vread_data(vread_data), .valu_out(valu_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .vrf_we(vrf_we), .vrf_waddr(vrf_waddr),
      .vrf_lane_base(vrf_lane_base), .vrf_lane_mask(vrf_lane_mask), .vrf_wdata(vrf_wdata),
      .busy(busy), .busy_vd(busy_vd)
   );

   writeback_stage_seq #(.LANES(3), .VWP(2)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t3_in_ready),
      .mem_to_reg(mem_to_reg), .vmem_to_reg(vmem_to_reg), .reg_write(reg_write),
      .vreg_write(vreg_write), .rd(rd), .vd(vd), .read_data(read_data), .alu_out(alu_out),
      .vread_data(vread_data[47:0]), .valu_out(valu_out[47:0]), .rf_we(t3_rf_we),
      .rf_waddr(t3_rf_waddr), .rf_wdata(t3_rf_wdata), .vrf_we(t3_vrf_we),
      .vrf_waddr(t3_vrf_waddr), .vrf_lane_base(t3_lane_base), .vrf_lane_mask(t3_lane_mask),
      .vrf_wdata(t3_wdata), .busy(t3_busy), .busy_vd(t3_busy_vd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; reg_write = 0; vreg_write = 0;
   endtask

   task automatic test_reset();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
      tests++; if (vrf_we !== 1'b0) begin fails++; $display("FAIL reset_vrf_we got %0b want 0", vrf_we); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
      tests++; if (vrf_lane_mask !== 2'b00) begin fails++; $display("FAIL reset_mask got %b want 00", vrf_lane_mask); end
      tests++; if (vrf_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", vrf_wdata); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_scalar();
      in_valid = 1; reg_write = 1; rd = 4'd3; mem_to_reg = 1; read_data = 8'hA5; alu_out = 8'h5A;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL scalar_ready_pre got %0b want 1", in_ready); end
      tick(); clear_inputs();
      tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL scalar_we got %0b want 1", rf_we); end
      tests++; if (rf_waddr !== 4'd3) begin fails++; $display("FAIL scalar_waddr got %0d want 3", rf_waddr); end
      tests++; if (rf_wdata !== 8'hA5) begin fails++; $display("FAIL scalar_wdata got %h want a5", rf_wdata); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL scalar_ready got %0b want 1", in_ready); end
      tests++; if (vrf_we !== 1'b0) begin fails++; $display("FAIL scalar_vrf_we got %0b want 0", vrf_we); end
      in_valid = 1; reg_write = 1; rd = 4'd7; mem_to_reg = 0; alu_out = 8'h3C;
      tick(); clear_inputs();
      tests++; if (rf_wdata !== 8'h3C) begin fails++; $display("FAIL scalar_alu_wdata got %h want 3c", rf_wdata); end
      tests++; if (rf_waddr !== 4'd7) begin fails++; $display("FAIL scalar_alu_waddr got %0d want 7", rf_waddr); end
      tick();
      tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL scalar_we_idle got %0b want 0", rf_we); end
      $display("[TB] test_scalar done");
   endtask

   task automatic test_vector();
      in_valid = 1; vreg_write = 1; vd = 4'd5; vmem_to_reg = 0;
      valu_out = 64'h4444_3333_2222_1111; vread_data = 64'hFFFF_EEEE_DDDD_CCCC;
      tick(); clear_inputs();
      tests++; if (vrf_we !== 1'b1) begin fails++; $display("FAIL vec_b0_we got %0b want 1", vrf_we); end
      tests++; if (vrf_waddr !== 4'd5) begin fails++; $display("FAIL vec_b0_waddr got %0d want 5", vrf_waddr); end
      tests++; if (vrf_lane_base !== 3'd0) begin fails++; $display("FAIL vec_b0_base got %0d want 0", vrf_lane_base); end
      tests++; if (vrf_lane_mask !== 2'b11) begin fails++; $display("FAIL vec_b0_mask got %b want 11", vrf_lane_mask); end
      tests++; if (vrf_wdata !== 32'h2222_1111) begin fails++; $display("FAIL vec_b0_data got %h want 22221111", vrf_wdata); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL vec_b0_ready got %0b want 0", in_ready); end
      tests++; if (busy !== 1'b1 || busy_vd !== 4'd5) begin fails++; $display("FAIL vec_b0_busy got %0b/%0d want 1/5", busy, busy_vd); end
      tests++; if (t3_wdata !== 32'h2222_1111 || t3_lane_mask !== 2'b11) begin fails++; $display("FAIL l3_b0 got %h/%b want 22221111/11", t3_wdata, t3_lane_mask); end
      tick();
      tests++; if (vrf_lane_base !== 3'd2) begin fails++; $display("FAIL vec_b1_base got %0d want 2", vrf_lane_base); end
      tests++; if (vrf_lane_mask !== 2'b11) begin fails++; $display("FAIL vec_b1_mask got %b want 11", vrf_lane_mask); end
      tests++; if (vrf_wdata !== 32'h4444_3333) begin fails++; $display("FAIL vec_b1_data got %h want 44443333", vrf_wdata); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL vec_b1_ready got %0b want 1", in_ready); end
      tests++; if (busy_vd !== 4'd5) begin fails++; $display("FAIL vec_b1_busy_vd got %0d want 5", busy_vd); end
      tests++; if (t3_lane_base !== 3'd2) begin fails++; $display("FAIL l3_b1_base got %0d want 2", t3_lane_base); end
      tests++; if (t3_lane_mask !== 2'b01) begin fails++; $display("FAIL l3_b1_mask got %b want 01", t3_lane_mask); end
      tests++; if (t3_wdata !== 32'h0000_3333) begin fails++; $display("FAIL l3_b1_data got %h want 00003333", t3_wdata); end
      tick();
      tests++; if (vrf_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL vec_end got we=%0b busy=%0b want 0/0", vrf_we, busy); end
      tests++; if (busy_vd !== 4'd0) begin fails++; $display("FAIL vec_end_busy_vd got %0d want 0", busy_vd); end
      tests++; if (t3_vrf_we !== 1'b0) begin fails++; $display("FAIL l3_end_we got %0b want 0", t3_vrf_we); end
      $display("[TB] test_vector done");
   endtask

   task automatic test_back_to_back();
      in_valid = 1; vreg_write = 1; vd = 4'd1; vmem_to_reg = 0; reg_write = 0;
      valu_out = 64'h0004_0003_0002_0001;
      tick();
      vd = 4'd2; vmem_to_reg = 1; vread_data = 64'hBBBB_AAAA_9999_8888;
      reg_write = 1; rd = 4'd4; mem_to_reg = 0; alu_out = 8'h77;
      tests++; if (vrf_waddr !== 4'd1 || vrf_wdata !== 32'h0002_0001) begin fails++; $display("FAIL b2b_c1 got %0d/%h want 1/00020001", vrf_waddr, vrf_wdata); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_c1_ready got %0b want 0", in_ready); end
      tick();
      tests++; if (vrf_we !== 1'b1 || vrf_waddr !== 4'd1 || vrf_lane_base !== 3'd2) begin fails++; $display("FAIL b2b_c2 got we=%0b addr=%0d base=%0d want 1/1/2", vrf_we, vrf_waddr, vrf_lane_base); end
      tests++; if (vrf_wdata !== 32'h0004_0003) begin fails++; $display("FAIL b2b_c2_data got %h want 00040003", vrf_wdata); end
      tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL b2b_c2_rf_we got %0b want 0", rf_we); end
      tick(); clear_inputs();
      tests++; if (vrf_we !== 1'b1 || vrf_waddr !== 4'd2 || vrf_lane_base !== 3'd0) begin fails++; $display("FAIL b2b_c3 got we=%0b addr=%0d base=%0d want 1/2/0", vrf_we, vrf_waddr, vrf_lane_base); end
      tests++; if (vrf_wdata !== 32'h9999_8888) begin fails++; $display("FAIL b2b_c3_data got %h want 99998888", vrf_wdata); end
      tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 8'h77) begin fails++; $display("FAIL b2b_c3_rf got %0b/%0d/%h want 1/4/77", rf_we, rf_waddr, rf_wdata); end
      tick();
      tests++; if (vrf_we !== 1'b1 || vrf_waddr !== 4'd2 || vrf_wdata !== 32'hBBBB_AAAA) begin fails++; $display("FAIL b2b_c4 got %0b/%0d/%h want 1/2/bbbbaaaa", vrf_we, vrf_waddr, vrf_wdata); end
      tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL b2b_c4_rf_we got %0b want 0", rf_we); end
      tick();
      tests++; if (vrf_we !== 1'b0) begin fails++; $display("FAIL b2b_c5_we got %0b want 0", vrf_we); end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_scalar_in_last_beat();
      in_valid = 1; vreg_write = 1; vd = 4'd6; vmem_to_reg = 0; valu_out = 64'h1234_5678_9ABC_DEF0;
      tick(); clear_inputs();
      tick();
      in_valid = 1; reg_write = 1; rd = 4'd9; mem_to_reg = 1; read_data = 8'hC3;
      tests++; if (vrf_we !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL slb_beat1 got we=%0b ready=%0b want 1/1", vrf_we, in_ready); end
      tick(); clear_inputs();
      tests++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 8'hC3) begin fails++; $display("FAIL slb_rf got %0b/%0d/%h want 1/9/c3", rf_we, rf_waddr, rf_wdata); end
      tests++; if (vrf_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL slb_vec got we=%0b busy=%0b want 0/0", vrf_we, busy); end
      tick();
      $display("[TB] test_scalar_in_last_beat done");
   endtask

   task automatic test_reset_mid_burst();
      in_valid = 1; vreg_write = 1; vd = 4'd7; reg_write = 1; rd = 4'd2; mem_to_reg = 0; alu_out = 8'h11;
      tick(); clear_inputs();
      tests++; if (vrf_we !== 1'b1 || rf_we !== 1'b1) begin fails++; $display("FAIL rmb_pre got vrf_we=%0b rf_we=%0b want 1/1", vrf_we, rf_we); end
      #2 rst = 1;
      #1;
      tests++; if (vrf_we !== 1'b0 || busy !== 1'b0 || busy_vd !== 4'd0) begin fails++; $display("FAIL rmb_async got we=%0b busy=%0b vd=%0d want 0/0/0", vrf_we, busy, busy_vd); end
      tests++; if (vrf_waddr !== 4'd0 || vrf_lane_mask !== 2'b00 || vrf_wdata !== 32'h0) begin fails++; $display("FAIL rmb_async_vec got %0d/%b/%h want 0/00/0", vrf_waddr, vrf_lane_mask, vrf_wdata); end
      tests++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rmb_async_sc got rf_we=%0b ready=%0b want 0/1", rf_we, in_ready); end
      @(negedge clk); rst = 0;
      tick();
      tests++; if (vrf_we !== 1'b0) begin fails++; $display("FAIL rmb_post1 got %0b want 0", vrf_we); end
      tick();
      tests++; if (vrf_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmb_post2 got we=%0b busy=%0b want 0/0", vrf_we, busy); end
      $display("[TB] test_reset_mid_burst done");
   endtask

   task automatic test_r0();
      in_valid = 1; reg_write = 1; rd = 4'd0; mem_to_reg = 0; alu_out = 8'hFF;
      tick(); clear_inputs();
      tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL r0_we got %0b want 0", rf_we); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL r0_ready got %0b want 1", in_ready); end
      $display("[TB] test_r0 done");
   endtask

   initial begin
      clk = 0; rst = 1;
      in_valid = 0; mem_to_reg = 0; vmem_to_reg = 0; reg_write = 0; vreg_write = 0;
      rd = '0; vd = '0; read_data = '0; alu_out = '0; vread_data = '0; valu_out = '0;
      #1;
      test_reset();
      @(negedge clk); rst = 0;
      test_scalar();
      test_vector();
      test_back_to_back();
      test_scalar_in_last_beat();
      test_reset_mid_burst();
      test_r0();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
